// File: rtl/w_sequencer_if.sv
// Control bundle between the hard-wired sequencer and the accumulator-machine datapath.
// The master modport is the sequencer; the slave modport is the datapath, memory and flags.
interface w_sequencer_if #(
    parameter int OPW = 3
);
    logic           start;
    logic           single;
    logic [OPW-1:0] opcode;
    logic           acc_neg;
    logic           acc_zero;
    logic           mem_ready;

    logic           Lin;
    logic           Lout;
    logic           inc;
    logic           Ain;
    logic           rd;
    logic           wr;
    logic           Sout;
    logic           Sin;
    logic           Iin;
    logic           Iaout;
    logic           Akin;
    logic           Akout;
    logic [1:0]     alu_op;
    logic           halted;

    modport master (
        input  start, single, opcode, acc_neg, acc_zero, mem_ready,
        output Lin, Lout, inc, Ain, rd, wr, Sout, Sin, Iin, Iaout,
               Akin, Akout, alu_op, halted
    );

    modport slave (
        output start, single, opcode, acc_neg, acc_zero, mem_ready,
        input  Lin, Lout, inc, Ain, rd, wr, Sout, Sin, Iin, Iaout,
               Akin, Akout, alu_op, halted
    );
endinterface

// File: rtl/w_sequencer.sv
// Hard-wired fetch/execute sequencer for the 8-instruction accumulator machine.
// State is registered; strobes decode combinationally from state, mem_ready and the flags.
module w_sequencer #(
    parameter int OPW = 3
) (
    input  logic          CLK,
    input  logic          nRST,
    w_sequencer_if.master bus
);
    localparam logic [OPW-1:0] OP_STP = OPW'(0);
    localparam logic [OPW-1:0] OP_DOD = OPW'(1);
    localparam logic [OPW-1:0] OP_ODE = OPW'(2);
    localparam logic [OPW-1:0] OP_POB = OPW'(3);
    localparam logic [OPW-1:0] OP_LAD = OPW'(4);
    localparam logic [OPW-1:0] OP_SOB = OPW'(5);
    localparam logic [OPW-1:0] OP_SOM = OPW'(6);
    localparam logic [OPW-1:0] OP_SOZ = OPW'(7);

    typedef enum logic [2:0] {
        S_HALT,
        S_F1,
        S_F2,
        S_DEC,
        S_EA,
        S_EM,
        S_EJ
    } state_t;

    state_t         state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    state_t         eoi_state;

    // Where an instruction goes once it has finished executing.
    assign eoi_state = bus.single ? S_HALT : S_F1;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_HALT: if (bus.start) state_d = S_F1;
            S_F1:   state_d = S_F2;
            S_F2:   if (bus.mem_ready) state_d = S_DEC;
            S_DEC: begin
                // I was loaded at the end of F2, so the opcode is valid only now.
                op_d = bus.opcode;
                case (bus.opcode)
                    OP_STP:                         state_d = S_HALT;
                    OP_DOD, OP_ODE, OP_POB, OP_LAD: state_d = S_EA;
                    default:                        state_d = S_EJ;
                endcase
            end
            S_EA:   state_d = S_EM;
            S_EM:   if (bus.mem_ready) state_d = eoi_state;
            S_EJ:   state_d = eoi_state;
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_HALT;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    logic       lin_c, lout_c, inc_c, ain_c, rd_c, wr_c, sout_c, sin_c;
    logic       iin_c, iaout_c, akin_c, akout_c;
    logic [1:0] alu_c;
    logic       jump_c;

    always_comb begin
        lin_c   = 1'b0;
        lout_c  = 1'b0;
        inc_c   = 1'b0;
        ain_c   = 1'b0;
        rd_c    = 1'b0;
        wr_c    = 1'b0;
        sout_c  = 1'b0;
        sin_c   = 1'b0;
        iin_c   = 1'b0;
        iaout_c = 1'b0;
        akin_c  = 1'b0;
        akout_c = 1'b0;
        alu_c   = 2'b00;
        jump_c  = 1'b0;
        case (state_q)
            S_F1: begin
                lout_c = 1'b1;
                ain_c  = 1'b1;
            end
            S_F2: begin
                rd_c   = 1'b1;
                sout_c = 1'b1;
                iin_c  = bus.mem_ready;
                inc_c  = bus.mem_ready;
            end
            S_EA: begin
                iaout_c = 1'b1;
                ain_c   = 1'b1;
            end
            S_EM: begin
                if (op_q == OP_LAD) begin
                    wr_c    = 1'b1;
                    akout_c = 1'b1;
                    sin_c   = 1'b1;
                end else begin
                    rd_c   = 1'b1;
                    sout_c = 1'b1;
                    akin_c = bus.mem_ready;
                    case (op_q)
                        OP_DOD:  alu_c = 2'b01;
                        OP_ODE:  alu_c = 2'b10;
                        default: alu_c = 2'b00;
                    endcase
                end
            end
            S_EJ: begin
                case (op_q)
                    OP_SOB:  jump_c = 1'b1;
                    OP_SOM:  jump_c = bus.acc_neg;
                    OP_SOZ:  jump_c = bus.acc_zero;
                    default: jump_c = 1'b0;
                endcase
                lin_c   = jump_c;
                iaout_c = jump_c;
            end
            default: ;
        endcase
    end

    assign bus.Lin    = lin_c;
    assign bus.Lout   = lout_c;
    assign bus.inc    = inc_c;
    assign bus.Ain    = ain_c;
    assign bus.rd     = rd_c;
    assign bus.wr     = wr_c;
    assign bus.Sout   = sout_c;
    assign bus.Sin    = sin_c;
    assign bus.Iin    = iin_c;
    assign bus.Iaout  = iaout_c;
    assign bus.Akin   = akin_c;
    assign bus.Akout  = akout_c;
    assign bus.alu_op = alu_c;
    assign bus.halted = (state_q == S_HALT);
endmodule

// File: tb/tb_w_sequencer.sv
// Directed scoreboard bench for w_sequencer: stimulus pushes the expected strobe vector
// for each cycle, a negedge monitor pops and compares it and checks bus-exclusivity rules.
module tb_w_sequencer;
    logic clk;
    logic nrst;

    w_sequencer_if #(.OPW(3)) bus ();

    w_sequencer #(.OPW(3)) dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector layout: Lin Lout inc Ain rd wr Sout Sin Iin Iaout Akin Akout alu_op[1:0] halted
    localparam logic [14:0] B_LIN   = 15'h4000;
    localparam logic [14:0] B_LOUT  = 15'h2000;
    localparam logic [14:0] B_INC   = 15'h1000;
    localparam logic [14:0] B_AIN   = 15'h0800;
    localparam logic [14:0] B_RD    = 15'h0400;
    localparam logic [14:0] B_WR    = 15'h0200;
    localparam logic [14:0] B_SOUT  = 15'h0100;
    localparam logic [14:0] B_SIN   = 15'h0080;
    localparam logic [14:0] B_IIN   = 15'h0040;
    localparam logic [14:0] B_IAOUT = 15'h0020;
    localparam logic [14:0] B_AKIN  = 15'h0010;
    localparam logic [14:0] B_AKOUT = 15'h0008;
    localparam logic [14:0] A_ADD   = 15'h0002;
    localparam logic [14:0] A_SUB   = 15'h0004;
    localparam logic [14:0] B_HALT  = 15'h0001;

    localparam logic [14:0] E_HALT = B_HALT;
    localparam logic [14:0] E_F1   = B_LOUT | B_AIN;
    localparam logic [14:0] E_F2W  = B_RD | B_SOUT;
    localparam logic [14:0] E_F2R  = B_RD | B_SOUT | B_IIN | B_INC;
    localparam logic [14:0] E_DEC  = 15'h0000;
    localparam logic [14:0] E_EA   = B_IAOUT | B_AIN;
    localparam logic [14:0] E_EMW  = B_RD | B_SOUT;
    localparam logic [14:0] E_EMR  = B_RD | B_SOUT | B_AKIN;
    localparam logic [14:0] E_LAD  = B_WR | B_AKOUT | B_SIN;
    localparam logic [14:0] E_JMP  = B_IAOUT | B_LIN;
    localparam logic [14:0] E_NOJ  = 15'h0000;

    localparam logic [2:0] STP = 3'd0, DOD = 3'd1, ODE = 3'd2, POB = 3'd3;
    localparam logic [2:0] LAD = 3'd4, SOB = 3'd5, SOM = 3'd6, SOZ = 3'd7;

    typedef struct {
        logic [14:0] v;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    logic [14:0] obs_v;
    assign obs_v = {bus.Lin, bus.Lout, bus.inc, bus.Ain, bus.rd, bus.wr, bus.Sout, bus.Sin,
                    bus.Iin, bus.Iaout, bus.Akin, bus.Akout, bus.alu_op, bus.halted};

    // Scoreboard monitor plus structural exclusivity rules, every cycle.
    always @(negedge clk) begin
        exp_t e;
        if (nrst) begin
            checks = checks + 4;
            if (bus.Lin && bus.inc) begin
                failures++;
                $display("FAIL lin_inc_excl: Lin=%b inc=%b required not both 1", bus.Lin, bus.inc);
            end
            if (bus.Lout && bus.Iaout) begin
                failures++;
                $display("FAIL abus_excl: Lout=%b Iaout=%b required not both 1", bus.Lout, bus.Iaout);
            end
            if (bus.Sout && bus.Akout) begin
                failures++;
                $display("FAIL dbus_excl: Sout=%b Akout=%b required not both 1", bus.Sout, bus.Akout);
            end
            if (bus.rd && bus.wr) begin
                failures++;
                $display("FAIL rd_wr_excl: rd=%b wr=%b required not both 1", bus.rd, bus.wr);
            end
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_v !== e.v) begin
                failures++;
                $display("FAIL %s: got %h required %h", e.name, obs_v, e.v);
            end else begin
                $display("ok   %s: %h", e.name, obs_v);
            end
        end
    end

    task automatic cyc(input logic st, input logic sg, input logic [2:0] op,
                       input logic ng, input logic zr, input logic mr,
                       input logic [14:0] ev, input string nm);
        exp_t t;
        bus.start     = st;
        bus.single    = sg;
        bus.opcode    = op;
        bus.acc_neg   = ng;
        bus.acc_zero  = zr;
        bus.mem_ready = mr;
        t.v    = ev;
        t.name = nm;
        exp_q.push_back(t);
        @(posedge clk);
        #1;
    endtask

    task automatic direct_check(input logic [14:0] ev, input string nm);
        checks++;
        if (obs_v !== ev) begin
            failures++;
            $display("FAIL %s: got %h required %h", nm, obs_v, ev);
        end else begin
            $display("ok   %s: %h", nm, obs_v);
        end
    endtask

    initial begin
        nrst          = 1'b0;
        bus.start     = 1'b0;
        bus.single    = 1'b0;
        bus.opcode    = 3'd0;
        bus.acc_neg   = 1'b0;
        bus.acc_zero  = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc(0, 0, STP, 0, 0, 1, E_HALT, "reset_hold");
        cyc(1, 0, STP, 0, 0, 1, E_HALT, "reset_start_ignored");
        nrst = 1'b1;
        cyc(0, 0, STP, 0, 0, 1, E_HALT, "halt_idle_mr_ignored");

        // POB, zero wait states
        cyc(1, 0, POB, 0, 0, 1, E_HALT, "pob_start");
        cyc(0, 0, POB, 0, 0, 1, E_F1,   "pob_f1");
        cyc(0, 0, POB, 0, 0, 1, E_F2R,  "pob_f2");
        cyc(0, 0, POB, 0, 0, 1, E_DEC,  "pob_dec");
        cyc(0, 0, POB, 0, 0, 1, E_EA,   "pob_ea");
        cyc(0, 0, POB, 0, 0, 1, E_EMR,  "pob_em");

        // DOD with 3 wait cycles in F2 and 2 in EM
        cyc(0, 0, DOD, 0, 0, 0, E_F1,          "dod_f1");
        cyc(0, 0, DOD, 0, 0, 0, E_F2W,         "dod_f2_w1");
        cyc(0, 0, DOD, 0, 0, 0, E_F2W,         "dod_f2_w2");
        cyc(0, 0, DOD, 0, 0, 0, E_F2W,         "dod_f2_w3");
        cyc(0, 0, DOD, 0, 0, 1, E_F2R,         "dod_f2_done");
        cyc(0, 0, DOD, 0, 0, 0, E_DEC,         "dod_dec");
        cyc(0, 0, DOD, 0, 0, 0, E_EA,          "dod_ea");
        cyc(0, 0, DOD, 0, 0, 0, E_EMW | A_ADD, "dod_em_w1");
        cyc(0, 0, DOD, 0, 0, 0, E_EMW | A_ADD, "dod_em_w2");
        cyc(0, 0, DOD, 0, 0, 1, E_EMR | A_ADD, "dod_em_done");

        // SOM taken / not taken, SOZ taken / not taken
        cyc(0, 0, SOM, 1, 0, 1, E_F1,  "som1_f1");
        cyc(0, 0, SOM, 1, 0, 1, E_F2R, "som1_f2");
        cyc(0, 0, SOM, 1, 0, 1, E_DEC, "som1_dec");
        cyc(0, 0, SOM, 1, 0, 1, E_JMP, "som1_ej_taken");
        cyc(0, 0, SOM, 0, 1, 1, E_F1,  "som0_f1");
        cyc(0, 0, SOM, 0, 1, 1, E_F2R, "som0_f2");
        cyc(0, 0, SOM, 0, 1, 1, E_DEC, "som0_dec");
        cyc(0, 0, SOM, 0, 1, 1, E_NOJ, "som0_ej_not_taken");
        cyc(0, 0, SOZ, 0, 1, 1, E_F1,  "soz1_f1");
        cyc(0, 0, SOZ, 0, 1, 1, E_F2R, "soz1_f2");
        cyc(0, 0, SOZ, 0, 1, 1, E_DEC, "soz1_dec");
        cyc(0, 0, SOZ, 0, 1, 1, E_JMP, "soz1_ej_taken");
        cyc(0, 0, SOZ, 1, 0, 1, E_F1,  "soz0_f1");
        cyc(0, 0, SOZ, 1, 0, 1, E_F2R, "soz0_f2");
        cyc(0, 0, SOZ, 1, 0, 1, E_DEC, "soz0_dec");
        cyc(0, 0, SOZ, 1, 0, 1, E_NOJ, "soz0_ej_not_taken");

        // LAD with two write wait states; start pulse mid-run must be ignored
        cyc(0, 0, LAD, 0, 0, 1, E_F1,  "lad_f1");
        cyc(0, 0, LAD, 0, 0, 1, E_F2R, "lad_f2");
        cyc(0, 0, LAD, 0, 0, 1, E_DEC, "lad_dec");
        cyc(1, 0, LAD, 0, 0, 1, E_EA,  "lad_ea_start_ignored");
        cyc(0, 0, LAD, 0, 0, 0, E_LAD, "lad_em_w1");
        cyc(0, 0, LAD, 0, 0, 0, E_LAD, "lad_em_w2");
        cyc(0, 0, LAD, 0, 0, 1, E_LAD, "lad_em_done");

        // ODE
        cyc(0, 0, ODE, 0, 0, 1, E_F1,          "ode_f1");
        cyc(0, 0, ODE, 0, 0, 1, E_F2R,         "ode_f2");
        cyc(0, 0, ODE, 0, 0, 1, E_DEC,         "ode_dec");
        cyc(0, 0, ODE, 0, 0, 1, E_EA,          "ode_ea");
        cyc(0, 0, ODE, 0, 0, 1, E_EMR | A_SUB, "ode_em");

        // STP halts after fetch
        cyc(0, 0, STP, 0, 0, 1, E_F1,   "stp_f1");
        cyc(0, 0, STP, 0, 0, 1, E_F2R,  "stp_f2");
        cyc(0, 0, STP, 0, 0, 1, E_DEC,  "stp_dec");
        cyc(0, 0, STP, 0, 0, 1, E_HALT, "stp_halt1");
        cyc(0, 0, STP, 0, 0, 1, E_HALT, "stp_halt2");

        // start + single: one SOB then HALT
        cyc(1, 1, SOB, 0, 0, 1, E_HALT, "sob_start_single");
        cyc(0, 1, SOB, 0, 0, 1, E_F1,   "sob_f1");
        cyc(0, 1, SOB, 0, 0, 1, E_F2R,  "sob_f2");
        cyc(0, 1, SOB, 0, 0, 1, E_DEC,  "sob_dec");
        cyc(0, 1, SOB, 0, 0, 1, E_JMP,  "sob_ej");
        cyc(0, 1, SOB, 0, 0, 1, E_HALT, "sob_single_halt");
        cyc(0, 0, SOB, 0, 0, 1, E_HALT, "sob_stays_halt");

        // Asynchronous reset in the middle of an F2 wait
        cyc(1, 0, DOD, 0, 0, 0, E_HALT, "rst_start");
        cyc(0, 0, DOD, 0, 0, 0, E_F1,   "rst_f1");
        cyc(0, 0, DOD, 0, 0, 0, E_F2W,  "rst_f2_w1");
        #2;
        direct_check(E_F2W, "rst_f2_w2_before");
        nrst = 1'b0;
        #1;
        direct_check(E_HALT, "rst_async_drop");
        @(posedge clk);
        #1;
        cyc(0, 0, DOD, 0, 0, 0, E_HALT, "rst_held");
        nrst = 1'b1;
        cyc(1, 0, DOD, 0, 0, 0, E_HALT, "rst_restart");
        cyc(0, 0, DOD, 0, 0, 0, E_F1,   "rst_restart_f1");

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
